// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: shift ops and FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/busy/done handshake bundle between a requester and the shift sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             carry;

  modport master (
    output start, op, amount, din,
    input  busy, done, dout, carry
  );

  modport slave (
    input  start, op, amount, din,
    output busy, done, dout, carry
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-position shift step; bit_out is the bit pushed off the end.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] w,
  input  op_t              op,
  output logic [WIDTH-1:0] w_next,
  output logic             bit_out
);

  always_comb begin
    w_next  = w;
    bit_out = 1'b0;
    case (op)
      SH_LSL: begin
        w_next  = {w[WIDTH-2:0], 1'b0};
        bit_out = w[WIDTH-1];
      end
      SH_LSR: begin
        w_next  = {1'b0, w[WIDTH-1:1]};
        bit_out = w[0];
      end
      SH_ASR: begin
        w_next  = {w[WIDTH-1], w[WIDTH-1:1]};
        bit_out = w[0];
      end
      default: begin
        w_next  = w;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shifter: one single-bit step per cycle, start/busy/done handshake.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  state_t           state, state_nxt;
  op_t              op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_step;
  logic             step_out;
  logic [WIDTH-1:0] dout_r;
  logic             carry_r;
  logic             zero_job;

  // A job with no op or no steps skips SHIFT and completes straight away.
  assign zero_job = (op_t'(bus.op) == SH_NONE) || (bus.amount == '0);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w       (w),
    .op      (op_q),
    .w_next  (w_step),
    .bit_out (step_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = zero_job ? S_DONE : S_SHIFT;
      S_SHIFT: if (count == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // dout is loaded on entry to DONE so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      carry_r <= 1'b0;
      dout_r  <= '0;
      op_q    <= SH_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            w       <= bus.din;
            op_q    <= op_t'(bus.op);
            count   <= bus.amount;
            carry_r <= 1'b0;
            if (zero_job) dout_r <= bus.din;
          end
        end
        S_SHIFT: begin
          w       <= w_step;
          carry_r <= step_out;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) dout_r <= w_step;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.dout  = dout_r;
  assign bus.carry = carry_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, start masking and reset abort.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  shift_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus ();

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start in the current cycle (cycle 0), follow to done, then one IDLE cycle.
  task automatic run_job(input string tag, input logic [1:0] op, input logic [3:0] amt,
                         input logic [15:0] din, input logic [15:0] exp_dout,
                         input logic exp_carry, input int exp_done_cyc, input bit noise);
    int cyc;
    bus.op = op; bus.amount = amt; bus.din = din; bus.start = 1'b1;
    tick();
    cyc = 1;
    if (noise) begin
      bus.din = 16'hFFFF; bus.op = 2'b10; bus.amount = 4'd1;
    end else begin
      bus.start = 1'b0; bus.din = 16'h5A5A; bus.op = 2'b11; bus.amount = 4'd9;
    end
    while (bus.done !== 1'b1 && cyc < 40) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done_cyc));
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    chk({tag, "_dout"}, 32'(bus.dout), 32'(exp_dout));
    chk({tag, "_carry"}, 32'(bus.carry), 32'(exp_carry));
    tick();
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_dout_hold"}, 32'(bus.dout), 32'(exp_dout));
    chk({tag, "_carry_hold"}, 32'(bus.carry), 32'(exp_carry));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.amount = 4'd0; bus.din = 16'h0000;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    reset = 1'b0;
    tick();

    run_job("lsl4", 2'b01, 4'd4, 16'h00F1, 16'h0F10, 1'b0, 5, 1'b0);
    run_job("asr3", 2'b11, 4'd3, 16'h8008, 16'hF001, 1'b0, 4, 1'b0);
    run_job("lsr1", 2'b10, 4'd1, 16'h0003, 16'h0001, 1'b1, 2, 1'b0);
    run_job("lsr15", 2'b10, 4'd15, 16'hFFFF, 16'h0001, 1'b1, 16, 1'b0);
    run_job("none7", 2'b00, 4'd7, 16'h1234, 16'h1234, 1'b0, 1, 1'b0);
    run_job("lsl0", 2'b01, 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1, 1'b0);
    run_job("lsr15b", 2'b10, 4'd15, 16'hFFFF, 16'h0001, 1'b1, 16, 1'b0);
    // Starts during SHIFT/DONE are ignored; next job begins in the IDLE after done.
    run_job("masked", 2'b01, 4'd4, 16'h00F1, 16'h0F10, 1'b0, 5, 1'b1);
    run_job("after_mask", 2'b11, 4'd2, 16'h8001, 16'hE000, 1'b0, 3, 1'b0);

    // Reset in cycle 3 of LSL 8 aborts the job.
    bus.op = 2'b01; bus.amount = 4'd8; bus.din = 16'h00FF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_dout", 32'(bus.dout), 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_job("post_reset", 2'b01, 4'd1, 16'h8001, 16'h0002, 1'b1, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
